// File: rtl/wait_merge_n_pkg.sv
// Shared types and helpers for the wait_merge_n join block.
// Holds the FSM state enum, its width, the delay-counter width and a clog2 helper.
package wait_merge_n_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned DLY_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 2'd0,
      ST_DELAY     = 2'd1,
      ST_WAIT_FREE = 2'd2
   } state_e;

   function automatic int unsigned clog2_f(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/wait_merge_chcnt.sv
// Per-channel pending-event counter, saturating at DEPTH.
// A drive arriving while full with no same-cycle consume is dropped and sets a sticky overflow flag.
module wait_merge_chcnt #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_avail,
   output logic o_ovf
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (i_inc && !i_dec) begin
         if (cnt_q == FULL) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (!i_inc && i_dec) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // A same-cycle drive counts as available so a join can complete on the arriving edge.
   assign o_avail = (cnt_q != '0) || i_inc;
   assign o_ovf   = ovf_q;

endmodule

// File: rtl/wait_merge_n.sv
// N-channel join: waits for one pending drive on every enabled channel, issues a delayed
// merged drive downstream, and returns per-channel frees when downstream frees.
module wait_merge_n
   import wait_merge_n_pkg::*;
#(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned DELAY_CYC = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] i_drive,
   output logic [N_CH-1:0] o_free,
   input  logic [N_CH-1:0] i_chEn,
   output logic            o_driveNext,
   input  logic            i_freeNext,
   output logic [N_CH:0]   o_err,
   output logic            o_busy
);

   localparam int unsigned      CW       = clog2_f(DEPTH + 1);
   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYC);

   state_e            state_q, state_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [N_CH-1:0]   grp_mask_q, grp_mask_d;
   logic [N_CH-1:0]   free_q, free_d;
   logic              drive_next_q, drive_next_d;
   logic              err_free_q, err_free_d;

   logic [N_CH-1:0]   avail;
   logic [N_CH-1:0]   ovf;
   logic [N_CH-1:0]   dec;
   logic              fire;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      wait_merge_chcnt #(
         .DEPTH (DEPTH),
         .CW    (CW)
      ) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .i_inc   (i_drive[g]),
         .i_dec   (dec[g]),
         .o_avail (avail[g]),
         .o_ovf   (ovf[g])
      );
   end

   // Fire is held off during the o_free cycle so a new group starts only on the following IDLE cycle.
   assign fire = (state_q == ST_IDLE) && (free_q == '0) && (i_chEn != '0)
                 && ((avail & i_chEn) == i_chEn);
   assign dec  = fire ? i_chEn : '0;

   always_comb begin
      state_d      = state_q;
      dly_d        = dly_q;
      grp_mask_d   = grp_mask_q;
      free_d       = '0;
      drive_next_d = 1'b0;
      err_free_d   = err_free_q | (i_freeNext && (state_q != ST_WAIT_FREE));
      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               grp_mask_d = i_chEn;
               dly_d      = DLY_LOAD;
               if (DELAY_CYC == 0) begin
                  drive_next_d = 1'b1;
                  state_d      = ST_WAIT_FREE;
               end else begin
                  state_d = ST_DELAY;
               end
            end
         end
         ST_DELAY: begin
            dly_d = dly_q - DLY_W'(1);
            if (dly_q == DLY_W'(1)) begin
               drive_next_d = 1'b1;
               state_d      = ST_WAIT_FREE;
            end
         end
         ST_WAIT_FREE: begin
            if (i_freeNext) begin
               free_d  = grp_mask_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         dly_q        <= '0;
         grp_mask_q   <= '0;
         free_q       <= '0;
         drive_next_q <= 1'b0;
         err_free_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         dly_q        <= dly_d;
         grp_mask_q   <= grp_mask_d;
         free_q       <= free_d;
         drive_next_q <= drive_next_d;
         err_free_q   <= err_free_d;
      end
   end

   assign o_free      = free_q;
   assign o_driveNext = drive_next_q;
   assign o_err       = {err_free_q, ovf};
   assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wait_merge_n.sv
// Directed bench for wait_merge_n: a DELAY_CYC=3 instance for join/queue/error/reset cases
// and a DELAY_CYC=0 instance for back-to-back throughput.
module tb_wait_merge_n;

   logic       clk;
   logic       rst;

   logic [3:0] drive_a, chen_a, free_a;
   logic       free_next_a, drive_next_a, busy_a;
   logic [4:0] err_a;

   logic [3:0] drive_z, chen_z, free_z;
   logic       free_next_z, drive_next_z, busy_z;
   logic [4:0] err_z;

   int unsigned n_tests;
   int unsigned n_fail;

   wait_merge_n #(
      .N_CH      (4),
      .DEPTH     (2),
      .DELAY_CYC (3)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .i_drive     (drive_a),
      .o_free      (free_a),
      .i_chEn      (chen_a),
      .o_driveNext (drive_next_a),
      .i_freeNext  (free_next_a),
      .o_err       (err_a),
      .o_busy      (busy_a)
   );

   wait_merge_n #(
      .N_CH      (4),
      .DEPTH     (2),
      .DELAY_CYC (0)
   ) dut_z (
      .clk         (clk),
      .rst         (rst),
      .i_drive     (drive_z),
      .o_free      (free_z),
      .i_chEn      (chen_z),
      .o_driveNext (drive_next_z),
      .i_freeNext  (free_next_z),
      .o_err       (err_z),
      .o_busy      (busy_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the merged drive, answers it in the same cycle, then checks the returned frees.
   task automatic run_group(input logic [3:0] exp_mask, input string tag);
      int unsigned n;
      n = 0;
      while (!drive_next_a && n < 20) begin
         tick();
         n++;
      end
      check_eq({tag, "_dn"}, 32'(drive_next_a), 32'd1);
      free_next_a = 1'b1;
      tick();
      free_next_a = 1'b0;
      check_eq({tag, "_free"}, 32'(free_a), 32'(exp_mask));
      tick();
      check_eq({tag, "_idle"}, 32'(busy_a), 32'd0);
   endtask

   logic        seen_dn, seen_free;
   int unsigned dn_edge[$];

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      drive_a     = '0;
      chen_a      = '0;
      free_next_a = 1'b0;
      drive_z     = '0;
      chen_z      = 4'hf;
      free_next_z = 1'b0;
      tick();
      tick();
      check_eq("rst_busy", 32'(busy_a), 32'd0);
      check_eq("rst_err",  32'(err_a),  32'd0);
      check_eq("rst_dn",   32'(drive_next_a), 32'd0);
      check_eq("rst_free", 32'(free_a), 32'd0);
      rst = 1'b0;

      // Staggered drives ch0..ch3; join completes on the ch3 edge.
      chen_a = 4'hf;
      for (int k = 0; k < 3; k++) begin
         drive_a = 4'(1 << k);
         tick();
      end
      drive_a = '0;
      check_eq("a_no_fire", 32'(busy_a), 32'd0);
      drive_a = 4'b1000;
      tick();
      drive_a = '0;
      check_eq("a_fire", 32'(busy_a), 32'd1);
      drive_a = 4'hf;                 // queued during DELAY
      tick();
      drive_a = '0;
      check_eq("a_dn_e1", 32'(drive_next_a), 32'd0);
      tick();
      check_eq("a_dn_e2", 32'(drive_next_a), 32'd0);
      tick();
      check_eq("a_dn_e3", 32'(drive_next_a), 32'd1);
      check_eq("a_free_early", 32'(free_a), 32'd0);
      tick();
      check_eq("a_dn_e4", 32'(drive_next_a), 32'd0);
      check_eq("a_wait_busy", 32'(busy_a), 32'd1);
      tick();
      free_next_a = 1'b1;
      tick();
      free_next_a = 1'b0;
      check_eq("a_free", 32'(free_a), 32'hf);
      check_eq("a_free_idle", 32'(busy_a), 32'd0);
      tick();
      check_eq("a_free_pulse", 32'(free_a), 32'd0);
      check_eq("a_gap", 32'(busy_a), 32'd0);
      tick();
      check_eq("a_requeue_fire", 32'(busy_a), 32'd1);
      run_group(4'hf, "a_q");

      // Partial mask 0101.
      chen_a  = 4'b0101;
      drive_a = 4'b0101;
      tick();
      drive_a = '0;
      check_eq("b_fire", 32'(busy_a), 32'd1);
      run_group(4'b0101, "b");
      chen_a  = 4'hf;
      drive_a = 4'b0101;
      tick();
      drive_a = '0;
      repeat (4) tick();
      check_eq("b_ch13_empty", 32'(busy_a), 32'd0);

      // Overflow on ch1, then two fires drain it.
      for (int k = 0; k < 3; k++) begin
         drive_a = 4'b0010;
         tick();
         drive_a = '0;
         tick();
      end
      check_eq("c_err", 32'(err_a), 32'h02);
      check_eq("c_blocked", 32'(busy_a), 32'd0);
      chen_a = 4'b0010;
      run_group(4'b0010, "c1");
      run_group(4'b0010, "c2");
      repeat (6) tick();
      check_eq("c_drained", 32'(busy_a), 32'd0);

      // Stray freeNext in IDLE, and an all-zero enable mask.
      chen_a      = 4'b0000;
      free_next_a = 1'b1;
      tick();
      free_next_a = 1'b0;
      check_eq("d_err", 32'(err_a), 32'h12);
      check_eq("d_free", 32'(free_a), 32'd0);
      check_eq("d_idle", 32'(busy_a), 32'd0);
      drive_a = 4'b1010;
      tick();
      drive_a = '0;
      repeat (3) tick();
      check_eq("d_zero_mask", 32'(busy_a), 32'd0);
      chen_a = 4'hf;
      tick();
      check_eq("d_accum_fire", 32'(busy_a), 32'd1);
      run_group(4'hf, "d");

      // Asynchronous reset during DELAY.
      drive_a = 4'hf;
      tick();
      drive_a = 4'b0001;
      check_eq("e_fire", 32'(busy_a), 32'd1);
      tick();
      drive_a = '0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("e_rst_busy", 32'(busy_a), 32'd0);
      check_eq("e_rst_err",  32'(err_a),  32'd0);
      check_eq("e_rst_dn",   32'(drive_next_a), 32'd0);
      check_eq("e_rst_free", 32'(free_a), 32'd0);
      tick();
      rst       = 1'b0;
      seen_dn   = 1'b0;
      seen_free = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         seen_dn   = seen_dn | drive_next_a;
         seen_free = seen_free | (free_a != '0);
      end
      check_eq("e_no_dn",   32'(seen_dn),   32'd0);
      check_eq("e_no_free", 32'(seen_free), 32'd0);
      drive_a = 4'b1110;
      tick();
      drive_a = '0;
      tick();
      check_eq("e_ch0_cleared", 32'(busy_a), 32'd0);
      drive_a = 4'b0001;
      tick();
      drive_a = '0;
      check_eq("e_refire", 32'(busy_a), 32'd1);
      run_group(4'hf, "e");

      // DELAY_CYC=0 throughput with continuous drives and same-cycle freeNext.
      drive_z = 4'hf;
      for (int unsigned e = 1; e <= 18; e++) begin
         tick();
         if (drive_next_z) dn_edge.push_back(e);
         free_next_z = drive_next_z;
      end
      drive_z     = '0;
      free_next_z = 1'b0;
      check_eq("z_count", 32'(dn_edge.size()), 32'd6);
      if (dn_edge.size() > 0) check_eq("z_first", dn_edge[0], 32'd1);
      for (int i = 1; i < dn_edge.size(); i++) begin
         check_eq("z_period", dn_edge[i] - dn_edge[i-1], 32'd3);
      end
      check_eq("z_err", 32'(err_z), 32'h0f);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wait_merge_n.md
WAIT_MERGE_N -- requirements
Module: wait_merge_n

Interface
REQ-001 Parameter N_CH, default 4, number of input channels to join (2..16).
REQ-002 Parameter DEPTH, default 2, max queued drive events per channel (1..15).
REQ-003 Parameter DELAY_CYC, default 2, cycles between join detection and o_driveNext (0..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_drive  input  N_CH  per-channel drive, one-cycle pulse per event.
REQ-007 o_free  output  N_CH  per-channel free, one-cycle pulse per consumed event.
REQ-008 i_chEn  input  N_CH  channel enable mask; sampled only in IDLE.
REQ-009 o_driveNext  output  1  merged drive to downstream, one-cycle pulse.
REQ-010 i_freeNext  input  1  downstream free, one-cycle pulse.
REQ-011 o_err  output  N_CH+1  sticky errors: bit i = channel i overflow, bit N_CH = unexpected i_freeNext.
REQ-012 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Per channel, a pending counter of width clog2(DEPTH+1) shall increment on i_drive[i] regardless of i_chEn or state.
REQ-014 i_drive[i] with counter = DEPTH and no same-cycle decrement shall be dropped and set o_err[i].
REQ-015 Same-cycle increment and decrement on one channel shall leave the counter unchanged.
REQ-016 States: IDLE, DELAY, WAIT_FREE; encoding 2 bits.
REQ-017 IDLE -> DELAY when i_chEn != 0 and every enabled channel's counter >= 1 ("fire").
REQ-018 On fire, enabled-channel counters shall decrement by one, i_chEn latched into grpMask, delay counter loaded with DELAY_CYC.
REQ-019 DELAY: counter decrements each cycle; at zero, o_driveNext pulses high for exactly one cycle and state -> WAIT_FREE.
REQ-020 Latency: fire at edge t -> o_driveNext high in the cycle after edge t+DELAY_CYC (DELAY_CYC=0 -> cycle after fire).
REQ-021 WAIT_FREE: on i_freeNext, o_free pulses grpMask for one cycle (registered, next cycle) and state -> IDLE.
REQ-022 i_freeNext in IDLE or DELAY shall be ignored and set o_err[N_CH].
REQ-023 i_chEn all-zero shall never fire; disabled channels keep accumulating up to DEPTH.
REQ-024 Back-to-back: fire is re-evaluated in the IDLE cycle following the o_free pulse; minimum period DELAY_CYC+3 cycles with immediate i_freeNext.
REQ-025 i_drive arriving during DELAY/WAIT_FREE shall queue, not join the in-flight group.
REQ-026 o_err bits clear only by rst.

Reset
REQ-027 rst asserted shall immediately force state IDLE, all counters 0, grpMask 0, o_driveNext 0, o_free 0, o_err 0, o_busy 0.
REQ-028 rst mid-operation shall discard in-flight group without emitting o_free; first fire possible in first edge after rst release.

Structure
REQ-029 Shared package holds state enum, state width and clog2 helper.
REQ-030 One sub-module, wait_merge_chcnt: per-channel saturating pending counter with overflow flag, instantiated N_CH times.

Verification
REQ-031 N_CH=4, DEPTH=2, DELAY_CYC=3, i_chEn=4'b1111; pulse drives ch0..3 in cycles 1..4 -> fire at edge 4, o_driveNext high cycle 8; i_freeNext cycle 10 -> o_free=4'b1111 cycle 11.
REQ-032 i_chEn=4'b0101, drives only ch0,ch2 -> fire, o_free=4'b0101; ch1,ch3 counters untouched.
REQ-033 Three drives on ch1 while idle-blocked -> counter 2, o_err=5'b00010, later two fires consume both.
REQ-034 i_freeNext pulsed in IDLE -> o_err[4]=1, no o_free, state stays IDLE.
REQ-035 rst asserted during DELAY -> outputs zero asynchronously, no o_driveNext or o_free after release until new drives.
REQ-036 DELAY_CYC=0, all drives same cycle with same-cycle freeNext repeats -> o_driveNext period exactly 3 cycles.
